alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 136 +++++++++++++
 tb/tb_alu_mc.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle bit-serial ALU: ADD/NAND with operand/result inversion, SLICE bits per cycle, LSB first.
// Optional build macro ALU_MC_ARITH_FLAGS_EN enables the carry/overflow flag logic (tied to 0 otherwise).
module alu_mc #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       opCode,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             negative,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam int NSL = WIDTH / SLICE;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             cy;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;

  logic [SLICE-1:0] sa;
  logic [SLICE-1:0] sb;
  logic [SLICE:0]   sum;
  logic [SLICE-1:0] r;
  logic [SLICE-1:0] rs;
  logic             cout;
  logic             last;
  logic [WIDTH-1:0] acc_n;

  // Slice datapath: operands are shifted right each cycle, so the active slice is always bits [SLICE-1:0]
  always_comb begin
    sa    = a_q[SLICE-1:0] ^ {SLICE{op_q[3]}};
    sb    = b_q[SLICE-1:0] ^ {SLICE{op_q[2]}};
    sum   = {1'b0, sa} + {1'b0, sb} + {{SLICE{1'b0}}, cy};
    r     = op_q[1] ? ~(sa & sb) : sum[SLICE-1:0];
    rs    = r ^ {SLICE{op_q[0]}};
    cout  = ~op_q[1] & sum[SLICE];
    last  = (cnt == CW'(NSL - 1));
    acc_n = (acc >> SLICE) | (WIDTH'(rs) << (WIDTH - SLICE));
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  // Control path and committed result; the result only moves on the final slice
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      cy       <= 1'b0;
      out      <= '0;
      negative <= 1'b0;
      zero     <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            cnt   <= '0;
            cy    <= 1'b0;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          cy  <= cout;
          cnt <= cnt + 1'b1;
          if (last) begin
            state    <= ST_DONE;
            out      <= acc_n;
            negative <= acc_n[WIDTH-1];
            zero     <= (acc_n == '0);
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Operand/accumulator registers carry no reset; the control path decides when they matter
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && in_valid) begin
      a_q  <= in1;
      b_q  <= in2;
      op_q <= opCode;
    end else if (state == ST_BUSY) begin
      a_q <= a_q >> SLICE;
      b_q <= b_q >> SLICE;
      acc <= acc_n;
    end
  end

`ifdef ALU_MC_ARITH_FLAGS_EN
  logic carry_q;
  logic ovf_q;
  logic ovf_s;

  // Signed overflow judged on the pre-inversion sum of the MSB slice
  assign ovf_s = ~op_q[1] & (sa[SLICE-1] == sb[SLICE-1]) & (sum[SLICE-1] != sa[SLICE-1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state == ST_BUSY && last) begin
      carry_q <= cout;
      ovf_q   <= ovf_s;
    end
  end

  assign carry    = carry_q;
  assign overflow = ovf_q;
`else
  assign carry    = 1'b0;
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH=16, SLICE=4.
module tb_alu_mc;

`ifdef ALU_MC_ARITH_FLAGS_EN
  localparam logic AF = 1'b1;
`else
  localparam logic AF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in1;
  logic [15:0] in2;
  logic [3:0]  opCode;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready;
  logic        negative;
  logic        zero;
  logic        carry;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int lat;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .opCode(opCode), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .negative(negative), .zero(zero), .carry(carry),
    .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, wait (bounded) for the result, check it, then hand it off
  task automatic op_check(input string tag, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] prev, input logic [15:0] eo,
                          input logic en, input logic ez, input logic ec, input logic ev);
    int n;
    opCode = op; in1 = a; in2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_busy_ready"}, in_ready, 1'b0);
    chk({tag, "_busy_out"}, out, prev);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_out"}, out, eo);
    chk({tag, "_neg"}, negative, en);
    chk({tag, "_zero"}, zero, ez);
    chk({tag, "_carry"}, carry, ec);
    chk({tag, "_ovf"}, overflow, ev);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_release_valid"}, out_valid, 1'b0);
    chk({tag, "_release_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in1 = 16'h0; in2 = 16'h0; opCode = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_out", out, 16'h0000);
    chk("rst_zero", zero, 1'b1);
    chk("rst_neg", negative, 1'b0);
    chk("rst_carry", carry, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_no_valid", in_ready, 1'b1);

    op_check("add3p5",  4'b0000, 16'h0003, 16'h0005, 16'h0000, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0);
    op_check("addffff", 4'b0000, 16'hFFFF, 16'h0001, 16'h0008, 16'h0000, 1'b0, 1'b1, AF,   1'b0);
    op_check("add7fff", 4'b0000, 16'h7FFF, 16'h0001, 16'h0000, 16'h8000, 1'b1, 1'b0, 1'b0, AF);
    op_check("sub",     4'b1001, 16'h000A, 16'h0003, 16'h8000, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0);
    op_check("nand",    4'b0010, 16'hF0F0, 16'hFF00, 16'h0007, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b0);

    // Hold in DONE with operands churning
    opCode = 4'b0000; in1 = 16'h1234; in2 = 16'h1111; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hold_latency", lat, 4);
    for (int i = 0; i < 5; i++) begin
      in1 = 16'($urandom); in2 = 16'($urandom); opCode = 4'(i + 3); in_valid = 1'b1;
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_out", out, 16'h2345);
      chk("hold_ready", in_ready, 1'b0);
      chk("hold_zero", zero, 1'b0);
      chk("hold_neg", negative, 1'b0);
      chk("hold_carry", carry, 1'b0);
      chk("hold_ovf", overflow, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("handoff_valid", out_valid, 1'b0);
    chk("handoff_ready", in_ready, 1'b1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("handoff_no_accept", in_ready, 1'b1);

    // Reset during the second BUSY cycle abandons the operation
    opCode = 4'b0000; in1 = 16'hFFFF; in2 = 16'h0001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_out", out, 16'h0000);
    chk("abort_zero", zero, 1'b1);
    chk("abort_neg", negative, 1'b0);
    chk("abort_carry", carry, 1'b0);
    chk("abort_ovf", overflow, 1'b0);
    chk("abort_ready", in_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_valid", out_valid, 1'b0);
      @(posedge clk); #1;
    end
    op_check("add1p1", 4'b0000, 16'h0001, 16'h0001, 16'h0000, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
